// File: rtl/im_loader.sv
// Instruction-memory loader: accepts a length-prefixed little-endian byte stream, packs it into
// 32-bit words and writes them from address 0 while holding the fetch stage. Build option: IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef IM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CKSUM, DONE} state_t;
  localparam state_t END_ST = CKSUM;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE} state_t;
  localparam state_t END_ST = DONE;
`endif

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [23:0]         word_q, word_d;
  logic [1:0]          idx_q, idx_d;
  logic [ADDR_W:0]     wl_q, wl_d, wl_inc;
  logic                err_q, err_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic                byte_ready_q, byte_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer;
  logic [16:0]         n_full;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]          cksum_q, cksum_d;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    idx_d      = idx_q;
    wl_d       = wl_q;
    err_d      = err_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif
    // byte_ready_q mirrors the current state, so this is not a comb path to byte_ready
    xfer   = byte_valid && byte_ready_q;
    n_full = {1'b0, byte_data, len_q[7:0]};
    wl_inc = wl_q + (ADDR_W+1)'(1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LEN_LO;
          err_d   = 1'b0;
          wl_d    = '0;
          idx_d   = '0;
`ifdef IM_LOADER_CHECKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          if (n_full > CAP) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (n_full == '0) begin
            state_d = END_ST;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef IM_LOADER_CHECKSUM_EN
          cksum_d = cksum_q ^ byte_data;
`endif
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Lanes 0..2 live in word_q; the 4th byte goes straight into the write word
            state_d    = WRITE;
            im_we_d    = 1'b1;
            im_addr_d  = wl_q[ADDR_W-1:0];
            im_wdata_d = {byte_data, word_q};
          end else begin
            word_d[8*idx_q +: 8] = byte_data;
          end
        end
      end
      WRITE: begin
        wl_d = wl_inc;
        if (17'(wl_inc) == {1'b0, len_q}) state_d = END_ST;
        else                              state_d = DATA;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CKSUM: begin
        if (xfer) begin
          err_d   = (byte_data != cksum_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA)
`ifdef IM_LOADER_CHECKSUM_EN
                   || (state_d == CKSUM)
`endif
                   ;
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      wl_q         <= '0;
      err_q        <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      wl_q         <= wl_d;
      err_q        <= err_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef IM_LOADER_CHECKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: framed loads, overflow, empty frame, checksum and mid-load reset.
module tb_im_loader;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem [0:63];
  int we_cnt = 0, xfer_cnt = 0, rdy_we_cnt = 0, hold_bad = 0;
  logic [ADDR_W-1:0] last_addr;
  bit in_load = 0;
  logic [7:0] frame [$];

  // Passive monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      we_cnt++;
      mem[im_addr] = im_wdata;
      last_addr = im_addr;
    end
    if (byte_valid === 1'b1 && byte_ready === 1'b1) xfer_cnt++;
    if (byte_ready === 1'b1 && im_we === 1'b1) rdy_we_cnt++;
    if (in_load && done !== 1'b1 && cpu_hold !== 1'b1) hold_bad++;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) got = 1;
    end
    @(posedge clk); #1;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL byte_timeout: byte_ready stayed %b, want 1", byte_ready);
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input int n_words);
    for (int k = 0; k < frame.size(); k++) begin
      send_byte(frame[k], gaps);
      if (k >= 2 && k < 2 + 4*n_words && ((k-2) % 4) == 3) begin
        n_tests++;
        if (im_we !== 1'b1 || im_addr !== ADDR_W'((k-2)/4)) begin
          n_fail++;
          $display("FAIL we_latency: im_we=%b im_addr=%0d, want 1/%0d", im_we, im_addr, (k-2)/4);
        end
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_load = 1;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b, want 1", done);
    end
    in_load = 0;
  endtask

  task automatic build_t1();
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};
`ifdef IM_LOADER_CHECKSUM_EN
    frame.push_back(8'hF0);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({byte_ready, im_we, cpu_hold, busy, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 000000", {byte_ready, im_we, cpu_hold, busy, done, err});
    end
    n_tests++;
    if (im_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d, want 0", im_addr); end
    n_tests++;
    if (im_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h, want 0", im_wdata); end
    n_tests++;
    if (words_loaded !== '0) begin n_fail++; $display("FAIL reset_wl: got %0d, want 0", words_loaded); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input bit gaps);
    int we0 = we_cnt, x0 = xfer_cnt, rw0 = rdy_we_cnt, hb0 = hold_bad;
    build_t1();
    do_start();
    n_tests++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_start gaps=%0d: hold/busy/done=%b%b%b, want 110", gaps, cpu_hold, busy, done);
    end
    send_frame(gaps, 2);
    wait_done();
    n_tests++;
    if (we_cnt - we0 !== 2) begin n_fail++; $display("FAIL basic_we_count gaps=%0d: got %0d, want 2", gaps, we_cnt - we0); end
    n_tests++;
    if (mem[0] !== 32'h00000013) begin n_fail++; $display("FAIL basic_word0 gaps=%0d: got %h, want 00000013", gaps, mem[0]); end
    n_tests++;
    if (mem[1] !== 32'h005000B3) begin n_fail++; $display("FAIL basic_word1 gaps=%0d: got %h, want 005000b3", gaps, mem[1]); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err gaps=%0d: got %b, want 0", gaps, err); end
    n_tests++;
    if (words_loaded !== 7'd2) begin n_fail++; $display("FAIL basic_wl gaps=%0d: got %0d, want 2", gaps, words_loaded); end
    n_tests++;
    if (xfer_cnt - x0 !== frame.size()) begin
      n_fail++; $display("FAIL basic_xfers gaps=%0d: got %0d, want %0d", gaps, xfer_cnt - x0, frame.size());
    end
    n_tests++;
    if (rdy_we_cnt - rw0 !== 0) begin n_fail++; $display("FAIL basic_ready_in_write gaps=%0d: got %0d, want 0", gaps, rdy_we_cnt - rw0); end
    n_tests++;
    if (hold_bad - hb0 !== 0 || cpu_hold !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold gaps=%0d: gaps_low=%0d hold_at_done=%b, want 0/0", gaps, hold_bad - hb0, cpu_hold);
    end
  endtask

  task automatic test_overflow();
    int we0 = we_cnt, x0;
    frame = '{8'h41, 8'h00};
    do_start();
    send_frame(1'b0, 0);
    wait_done();
    n_tests++;
    if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL ovf_we_count: got %0d, want 0", we_cnt - we0); end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b, want 1", err); end
    n_tests++;
    if (words_loaded !== '0) begin n_fail++; $display("FAIL ovf_wl: got %0d, want 0", words_loaded); end
    // A byte offered in DONE must not be taken
    x0 = xfer_cnt;
    byte_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    byte_valid = 1'b0;
    n_tests++;
    if (xfer_cnt - x0 !== 0 || byte_ready !== 1'b0) begin
      n_fail++; $display("FAIL done_no_accept: xfers=%0d ready=%b, want 0/0", xfer_cnt - x0, byte_ready);
    end
  endtask

  task automatic test_full_capacity();
    int we0 = we_cnt;
    frame = '{8'h40, 8'h00};
    for (int i = 0; i < 256; i++) frame.push_back(8'(i));
`ifdef IM_LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    do_start();
    send_frame(1'b0, 64);
    wait_done();
    n_tests++;
    if (we_cnt - we0 !== 64) begin n_fail++; $display("FAIL full_we_count: got %0d, want 64", we_cnt - we0); end
    n_tests++;
    if (last_addr !== 6'd63) begin n_fail++; $display("FAIL full_last_addr: got %0d, want 63", last_addr); end
    n_tests++;
    if (mem[0] !== 32'h03020100) begin n_fail++; $display("FAIL full_word0: got %h, want 03020100", mem[0]); end
    n_tests++;
    if (mem[63] !== 32'hFFFEFDFC) begin n_fail++; $display("FAIL full_word63: got %h, want fffefdfc", mem[63]); end
    n_tests++;
    if (words_loaded !== 7'd64 || err !== 1'b0) begin
      n_fail++; $display("FAIL full_wl_err: got %0d/%b, want 64/0", words_loaded, err);
    end
  endtask

  task automatic test_zero_len();
    int we0 = we_cnt;
    frame = '{8'h00, 8'h00};
`ifdef IM_LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    do_start();
    send_frame(1'b0, 0);
    wait_done();
    n_tests++;
    if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL zero_we_count: got %0d, want 0", we_cnt - we0); end
    n_tests++;
    if (err !== 1'b0 || words_loaded !== '0) begin
      n_fail++; $display("FAIL zero_err_wl: got %b/%0d, want 0/0", err, words_loaded);
    end
  endtask

`ifdef IM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int we0;
    frame = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    do_start();
    send_frame(1'b0, 1);
    wait_done();
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL cksum_good_err: got %b, want 0", err); end
    we0 = we_cnt;
    frame = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_start();
    send_frame(1'b0, 1);
    wait_done();
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL cksum_bad_err: got %b, want 1", err); end
    n_tests++;
    if (we_cnt - we0 !== 1 || mem[0] !== 32'h04030201) begin
      n_fail++; $display("FAIL cksum_bad_write: count=%0d word=%h, want 1/04030201", we_cnt - we0, mem[0]);
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    int we0 = we_cnt;
    frame = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    do_start();
    send_frame(1'b0, 2);
    in_load = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({cpu_hold, busy, im_we, byte_ready, done} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_flags: got %b, want 00000", {cpu_hold, busy, im_we, byte_ready, done});
    end
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_tests++;
    if (we_cnt - we0 !== 1 || mem[0] !== 32'hDDCCBBAA) begin
      n_fail++; $display("FAIL midrst_writes: count=%0d word0=%h, want 1/ddccbbaa", we_cnt - we0, mem[0]);
    end
    test_basic(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_overflow();
    test_full_capacity();
    test_zero_len();
`ifdef IM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
